// File: rtl/packet_transmitter_if.sv
// rtl/packet_transmitter_if.sv - host request/payload and router packet signals of packet_transmitter
interface packet_transmitter_if;
    logic       i_Start;
    logic [1:0] i_Address;
    logic [5:0] i_Length;
    logic [7:0] i_Payload_Data;
    logic       i_Payload_Valid;
    logic       o_Payload_Ready;
    logic       i_Sig_Busy;
    logic       o_Valid_Packet;
    logic [7:0] o_Output_Data;
    logic       o_Tx_Busy;
    logic       o_Done;
    logic       o_Request_Error;

    // slave is the transmitter itself; master is the host/router environment around it
    modport slave (
        input  i_Start, i_Address, i_Length, i_Payload_Data, i_Payload_Valid, i_Sig_Busy,
        output o_Payload_Ready, o_Valid_Packet, o_Output_Data, o_Tx_Busy, o_Done, o_Request_Error
    );

    modport master (
        output i_Start, i_Address, i_Length, i_Payload_Data, i_Payload_Valid, i_Sig_Busy,
        input  o_Payload_Ready, o_Valid_Packet, o_Output_Data, o_Tx_Busy, o_Done, o_Request_Error
    );
endinterface

// File: rtl/packet_transmitter.sv
// rtl/packet_transmitter.sv - buffers a payload, then streams header, payload and parity to the router
module packet_transmitter #(
    parameter int MAX_LENGTH = 63
) (
    input  logic               clk,
    input  logic               reset,
    packet_transmitter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, DONE} state_t;

    state_t     state;
    logic [1:0] addr_q;
    logic [5:0] len_q;
    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr;
    logic [7:0] acc;
    logic [7:0] buffer [MAX_LENGTH];

    logic       req_legal;
    logic       load_last;
    logic [5:0] rd_next;

    assign req_legal = (bus.i_Address != 2'd3) && (bus.i_Length != 6'd0) &&
                       ({1'b0, bus.i_Length} <= 7'(MAX_LENGTH));
    assign load_last = bus.i_Payload_Valid && (wr_ptr == len_q - 6'd1);
    assign rd_next   = rd_ptr + 6'd1;

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && bus.i_Payload_Valid)
            buffer[wr_ptr] <= bus.i_Payload_Data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            addr_q              <= 2'd0;
            len_q               <= 6'd0;
            wr_ptr              <= 6'd0;
            rd_ptr              <= 6'd0;
            acc                 <= 8'h00;
            bus.o_Valid_Packet  <= 1'b0;
            bus.o_Output_Data   <= 8'h00;
            bus.o_Payload_Ready <= 1'b0;
            bus.o_Tx_Busy       <= 1'b0;
            bus.o_Done          <= 1'b0;
            bus.o_Request_Error <= 1'b0;
        end else begin
            bus.o_Done          <= 1'b0;
            bus.o_Request_Error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_Start) begin
                        if (req_legal) begin
                            addr_q              <= bus.i_Address;
                            len_q               <= bus.i_Length;
                            wr_ptr              <= 6'd0;
                            state               <= LOAD;
                            bus.o_Payload_Ready <= 1'b1;
                            bus.o_Tx_Busy       <= 1'b1;
                        end else begin
                            bus.o_Request_Error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.i_Payload_Valid) begin
                        wr_ptr <= wr_ptr + 6'd1;
                        if (load_last) begin
                            state               <= HEADER;
                            bus.o_Payload_Ready <= 1'b0;
                            bus.o_Valid_Packet  <= 1'b1;
                            bus.o_Output_Data   <= {len_q, addr_q};
                            acc                 <= {len_q, addr_q};
                        end
                    end
                end
                HEADER: begin
                    if (!bus.i_Sig_Busy) begin
                        state             <= PAYLOAD;
                        rd_ptr            <= 6'd0;
                        bus.o_Output_Data <= buffer[0];
                    end
                end
                PAYLOAD: begin
                    // The byte on the bus is the one being accepted, so fold it in now.
                    if (!bus.i_Sig_Busy) begin
                        acc <= acc ^ bus.o_Output_Data;
                        if (rd_ptr == len_q - 6'd1) begin
                            state              <= PARITY;
                            bus.o_Valid_Packet <= 1'b0;
                            bus.o_Output_Data  <= acc ^ bus.o_Output_Data;
                        end else begin
                            rd_ptr            <= rd_next;
                            bus.o_Output_Data <= buffer[rd_next];
                        end
                    end
                end
                PARITY: begin
                    if (!bus.i_Sig_Busy) begin
                        state             <= DONE;
                        bus.o_Done        <= 1'b1;
                        bus.o_Output_Data <= 8'h00;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.o_Tx_Busy <= 1'b0;
                end
                default: begin
                    state               <= IDLE;
                    bus.o_Valid_Packet  <= 1'b0;
                    bus.o_Payload_Ready <= 1'b0;
                    bus.o_Tx_Busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/packet_transmitter.md
# packet_transmitter

Source-side packet generator that drives the input port of the 1x3 packet router. It accepts a transmit request, destination address and length from a host. It buffers the payload bytes, then streams header, payload and parity bytes onto the router's 8-bit packet interface. While streaming it obeys the router's busy back-pressure. It is the transmitting end of the router's input protocol and sits between a traffic source (CPU bridge or testbench master) and the router.

## Interface
- MAX_LENGTH, 63, payload buffer depth in bytes; must be ≤63, because the length field is 6 bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- i_Start  input  1  transmit request; sampled only in IDLE.
- i_Address  input  2  destination port, 0..2; 3 is illegal.
- i_Length  input  6  payload byte count, 1..MAX_LENGTH; 0 is illegal.
- i_Payload_Data  input  8  payload byte from the source.
- i_Payload_Valid  input  1  payload byte valid.
- o_Payload_Ready  output  1  block can accept a payload byte.
- i_Sig_Busy  input  1  router busy; freezes the current output beat.
- o_Valid_Packet  output  1  packet-valid to the router.
- o_Output_Data  output  8  byte to the router.
- o_Tx_Busy  output  1  high in every state except IDLE.
- o_Done  output  1  one-cycle pulse after the parity beat is accepted.
- o_Request_Error  output  1  one-cycle pulse when a request is rejected.

## Operation
- Packet format on the wire:
  - header = {length[5:0], address[1:0]};
  - then `length` payload bytes;
  - then one parity byte equal to the XOR of the header and all payload bytes.
- o_Valid_Packet is high for the header and payload beats and low for the parity beat.
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, DONE.
- IDLE:
  - On i_Start=1 with legal address and length: latch address and length, clear the write pointer, go to LOAD.
  - On i_Start=1 with address=3, length=0 or length>MAX_LENGTH: pulse o_Request_Error for one cycle and stay in IDLE.
- LOAD:
  - o_Payload_Ready=1.
  - Each cycle with i_Payload_Valid=1 writes the byte to buffer[wr_ptr] and increments wr_ptr.
  - Gaps in i_Payload_Valid are tolerated.
  - When the byte at index length-1 is accepted, go to HEADER. o_Payload_Ready drops the following cycle.
- HEADER: drive o_Valid_Packet=1 and o_Output_Data=header. Initialise the parity accumulator to the header value.
- PAYLOAD: drive buffer[rd_ptr] with o_Valid_Packet=1. Each accepted beat XORs that byte into the accumulator and increments rd_ptr. After the beat at index length-1, go to PARITY.
- PARITY: drive o_Valid_Packet=0 and o_Output_Data=accumulator. When accepted, go to DONE.
- DONE: pulse o_Done for one cycle, then return to IDLE.
- Beat acceptance:
  - A beat is accepted at a rising edge in HEADER, PAYLOAD or PARITY when i_Sig_Busy=0.
  - While i_Sig_Busy=1, state, pointers, accumulator, o_Output_Data and o_Valid_Packet all hold.
- Payload stream: once HEADER is entered, the stream is contiguous apart from busy stalls. Payload underrun is impossible by construction.
- i_Start outside IDLE is ignored; no error pulse.
- The buffer is single-port write in LOAD and read in PAYLOAD. Its contents are not reset.

## Timing
- Reset (asynchronous, reset=0) forces:
  - state=IDLE;
  - o_Valid_Packet=0, o_Output_Data=8'h00, o_Payload_Ready=0, o_Tx_Busy=0, o_Done=0, o_Request_Error=0;
  - pointers and accumulator to 0.
- Reset mid-packet abandons the packet immediately. o_Valid_Packet falls asynchronously and no parity byte is sent.
- All outputs are registered.
- o_Payload_Ready rises 1 cycle after i_Start is accepted.
- The header appears 1 cycle after the last payload byte is written.
- Unstalled transmission takes length+2 cycles: header, payload, parity. o_Done follows the parity beat by 1 cycle.
- Minimum spacing between packets: i_Start sampled in the cycle after o_Done.
- With no stalls, total latency from i_Start to o_Done is 1 + (LOAD cycles) + length + 2 + 1.
- i_Sig_Busy asserted on the parity beat holds parity on the bus with o_Valid_Packet=0 until busy clears.

## Test plan
- Basic packet: addr=1, len=3, payload A5,3C,0F, no stalls.
  - Bus shows 0D, A5, 3C, 0F with valid=1, then 9B with valid=0.
  - o_Done pulses once.
- Busy stall: same packet with i_Sig_Busy=1 for 2 cycles during HEADER and 1 cycle during the second payload beat.
  - 0D is held 3 cycles and 3C is held 2 cycles.
  - Sequence and parity 9B are unchanged.
- Illegal requests:
  - addr=3, len=4 gives an o_Request_Error pulse; state stays IDLE; o_Valid_Packet never rises.
  - addr=0, len=0 behaves the same.
- Max length: addr=2, len=63, payload 00..3E with random gaps in i_Payload_Valid.
  - Header FE, then 63 contiguous bytes 00..3E, then parity C1.
  - Total of 65 beats.
- Reset mid-payload: assert reset=0 during the 2nd payload beat of a len=5 packet.
  - Outputs go to 0 immediately.
  - After release, a new addr=0, len=1, payload 55 gives 04, 55, then parity 51.
- Start while busy: pulse i_Start during PAYLOAD.
  - Ignored; no error pulse; the current packet completes unchanged.
